// File: rtl/alu_pwm_pkg.sv
// Shared widths, constants and FSM state type for the ALU-driven PWM generator.
package alu_pwm_pkg;
    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] CNT_MAX = 8'hFF;

    typedef enum logic {IDLE, PENDING} pwm_state_t;
endpackage

// File: rtl/pwm_prescaler.sv
// Free-running prescaler: tick is high on the last of every PRESC clocks.
module pwm_prescaler #(
    parameter int PRESC = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

    logic [PW-1:0] r_pcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pcnt <= '0;
        else if (r_pcnt == LAST)
            r_pcnt <= '0;
        else
            r_pcnt <= r_pcnt + 1'b1;
    end

    assign tick = (r_pcnt == LAST);
endmodule

// File: rtl/alu_pwm_gen.sv
// PWM generator fed by the ALU result bus; duty is double-buffered and committed on period wrap.
// Optional flag filter on capture enabled by macro ALU_PWM_FLAG_GUARD_EN.
module alu_pwm_gen
    import alu_pwm_pkg::*;
#(
    parameter int PRESC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] num,
    input  logic              neg,
    input  logic              cero,
    input  logic              carry,
    input  logic              des,
    input  logic              load,
    output logic              load_ack,
    output logic              pwm_out,
    output logic              period_end,
    output logic [DUTY_W-1:0] duty
);
    pwm_state_t        r_state, w_state_nxt;
    logic [DUTY_W-1:0] r_cnt;
    logic [DUTY_W-1:0] r_duty_active;
    logic [DUTY_W-1:0] r_duty_pending;
    logic              r_pwm_out;
    logic              r_load_ack;
    logic              r_period_end;
    logic              w_tick;
    logic              w_commit;
    logic [DUTY_W-1:0] w_filtered;
    logic              w_unused_flags;

    pwm_prescaler #(.PRESC(PRESC)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

`ifdef ALU_PWM_FLAG_GUARD_EN
    // Negative results clamp off, overflowed results clamp to maximum.
    assign w_filtered     = neg ? '0 : (des ? CNT_MAX : num);
    assign w_unused_flags = ^{cero, carry};
`else
    assign w_filtered     = num;
    assign w_unused_flags = ^{cero, carry, neg, des};
`endif

    assign w_commit = w_tick && (r_cnt == CNT_MAX);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (load) w_state_nxt = PENDING;
            PENDING: if (w_commit && !load) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_duty_active  <= '0;
            r_duty_pending <= '0;
            r_pwm_out      <= 1'b0;
            r_load_ack     <= 1'b0;
            r_period_end   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tick)
                r_cnt <= r_cnt + 1'b1;
            if (load)
                r_duty_pending <= w_filtered;
            // A load on the commit edge still commits the previously pending value.
            if (w_commit && r_state == PENDING)
                r_duty_active <= r_duty_pending;
            r_pwm_out    <= (r_cnt < r_duty_active);
            r_load_ack   <= load;
            r_period_end <= w_commit;
        end
    end

    assign pwm_out    = r_pwm_out;
    assign load_ack   = r_load_ack;
    assign period_end = r_period_end;
    assign duty       = r_duty_active;
endmodule

// File: tb/tb_alu_pwm_gen.sv
// Directed bench for alu_pwm_gen at PRESC=1 (period = 256 clocks).
module tb_alu_pwm_gen;
    import alu_pwm_pkg::*;

`ifdef ALU_PWM_FLAG_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] num = '0;
    logic       neg = 1'b0, cero = 1'b0, carry = 1'b0, des = 1'b0, load = 1'b0;
    logic       load_ack, pwm_out, period_end;
    logic [7:0] duty;

    int n_vec = 0;
    int n_err = 0;

    alu_pwm_gen #(.PRESC(1)) dut (
        .clk(clk), .rst(rst), .num(num), .neg(neg), .cero(cero), .carry(carry),
        .des(des), .load(load), .load_ack(load_ack), .pwm_out(pwm_out),
        .period_end(period_end), .duty(duty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] num;
        logic       neg;
        logic       des;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Step until period_end; counts cycles taken and cycles where duty left 'hold' beforehand.
    task automatic wait_pe(input logic [7:0] hold, output int n, output int bad);
        bit seen = 1'b0;
        n = 0;
        bad = 0;
        for (int k = 0; k < 600 && !seen; k++) begin
            step();
            n++;
            if (period_end) seen = 1'b1;
            else if (duty != hold) bad++;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_period_end: got timeout, expected pulse within 600 cycles");
        end
    endtask

    task automatic count_period(output int hi);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (pwm_out) hi++;
        end
    endtask

    task automatic pulse_load(input logic [7:0] v, input logic n_f, input logic d_f);
        load = 1'b1; num = v; neg = n_f; des = d_f;
        cero = (v == 8'd0); carry = ~carry;
        step();
        load = 1'b0; neg = 1'b0; des = 1'b0;
    endtask

    initial begin
        int hi, n, bad, pe_cnt, pe1, pe2, dnz;
        logic [7:0] hold;

        vecs[0] = '{8'd128, 1'b0, 1'b0, 8'd128};
        vecs[1] = '{8'd0,   1'b0, 1'b0, 8'd0};
        vecs[2] = '{8'd255, 1'b0, 1'b0, 8'd255};
        vecs[3] = '{8'd1,   1'b0, 1'b0, 8'd1};
        vecs[4] = '{8'hF7,  1'b1, 1'b0, GUARD ? 8'd0   : 8'd247};
        vecs[5] = '{8'd30,  1'b0, 1'b1, GUARD ? 8'd255 : 8'd30};
        vecs[6] = '{8'd77,  1'b0, 1'b0, 8'd77};
        vecs[7] = '{8'hF7,  1'b1, 1'b1, GUARD ? 8'd0   : 8'd247};

        // Reset state and idle behaviour
        rst = 1'b1;
        #2;
        chk("reset_pwm_out", int'(pwm_out), 0);
        chk("reset_duty", int'(duty), 0);
        chk("reset_load_ack", int'(load_ack), 0);
        chk("reset_period_end", int'(period_end), 0);
        do_reset();
        hi = 0; pe_cnt = 0; pe1 = -1; pe2 = -1; dnz = 0;
        for (int c = 1; c <= 600; c++) begin
            step();
            if (pwm_out) hi++;
            if (duty != 8'd0) dnz++;
            if (period_end) begin
                pe_cnt++;
                if (pe_cnt == 1) pe1 = c;
                else if (pe_cnt == 2) pe2 = c;
            end
        end
        chk("idle_pwm_high", hi, 0);
        chk("idle_duty", dnz, 0);
        chk("idle_pe_count", pe_cnt, 2);
        chk("idle_pe_first", pe1, 256);
        chk("idle_pe_second", pe2, 512);

        // Single load at cycle 10
        do_reset();
        for (int c = 1; c <= 9; c++) step();
        pulse_load(8'd128, 1'b0, 1'b0);
        chk("single_ack_hi", int'(load_ack), 1);
        step();
        chk("single_ack_lo", int'(load_ack), 0);
        chk("single_duty_before", int'(duty), 0);
        wait_pe(8'd0, n, bad);
        chk("single_early_duty", bad, 0);
        chk("single_commit_cycle", n, 245);
        chk("single_duty", int'(duty), 128);
        count_period(hi);
        chk("single_high_steps", hi, 128);

        // Last write wins, with back-to-back loads
        pulse_load(8'd64, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) step();
        load = 1'b1; num = 8'd77;
        step();
        chk("b2b_ack1", int'(load_ack), 1);
        num = 8'd200;
        step();
        chk("b2b_ack2", int'(load_ack), 1);
        load = 1'b0;
        step();
        chk("b2b_ack_lo", int'(load_ack), 0);
        wait_pe(8'd128, n, bad);
        chk("lww_duty_held", bad, 0);
        chk("lww_duty", int'(duty), 200);
        count_period(hi);
        chk("lww_high_steps", hi, 200);

        // Load on the commit edge
        pulse_load(8'd50, 1'b0, 1'b0);
        for (int c = 0; c < 254; c++) step();
        chk("ce_pre_commit_pe", int'(period_end), 0);
        load = 1'b1; num = 8'd90;
        step();
        load = 1'b0;
        chk("ce_period_end", int'(period_end), 1);
        chk("ce_duty_now", int'(duty), 50);
        chk("ce_ack", int'(load_ack), 1);
        count_period(hi);
        chk("ce_high_50", hi, 50);
        chk("ce_pe_next", int'(period_end), 1);
        chk("ce_duty_next", int'(duty), 90);
        count_period(hi);
        chk("ce_high_90", hi, 90);

        // Table-driven captures (filter behaviour depends on the build)
        hold = 8'd90;
        for (int i = 0; i < 8; i++) begin
            pulse_load(vecs[i].num, vecs[i].neg, vecs[i].des);
            chk($sformatf("vec%0d_ack", i), int'(load_ack), 1);
            wait_pe(hold, n, bad);
            chk($sformatf("vec%0d_duty_held", i), bad, 0);
            chk($sformatf("vec%0d_duty", i), int'(duty), int'(vecs[i].exp));
            count_period(hi);
            chk($sformatf("vec%0d_high_steps", i), hi, int'(vecs[i].exp));
            hold = vecs[i].exp;
        end

        // Reset mid-period with duty 100
        pulse_load(8'd100, 1'b0, 1'b0);
        wait_pe(hold, n, bad);
        chk("mid_duty", int'(duty), 100);
        for (int c = 0; c < 40; c++) step();
        chk("mid_pwm_before", int'(pwm_out), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_duty", int'(duty), 0);
        step();
        step();
        rst = 1'b0;
        hi = 0; pe1 = -1; dnz = 0;
        for (int c = 1; c <= 600; c++) begin
            step();
            if (pwm_out) hi++;
            if (duty != 8'd0) dnz++;
            if (period_end && pe1 < 0) pe1 = c;
        end
        chk("post_rst_pwm_high", hi, 0);
        chk("post_rst_duty", dnz, 0);
        chk("post_rst_first_pe", pe1, 256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_pwm_gen.md
# alu_pwm_gen

Consumes the ALU result and flags and turns them into a PWM waveform. It is the reader side of the ALU result bus, sitting between the ALU and the PWM output pin. A captured 8-bit result becomes the duty cycle. Duty changes are double-buffered so that a new value only takes effect at a period boundary, which prevents glitched periods.

## Interface
- `PRESC`, default 4: clock cycles per PWM counter step; must be ≥ 1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `num`  in  8  ALU result; unsigned duty request.
- `neg`  in  1  ALU negative flag.
- `cero`  in  1  ALU zero flag; informational only, not used in logic.
- `carry`  in  1  ALU carry flag; informational only, not used in logic.
- `des`  in  1  ALU overflow flag.
- `load`  in  1  one-cycle strobe: sample `num` and the flags this cycle.
- `load_ack`  out  1  one-cycle pulse acknowledging an accepted `load`.
- `pwm_out`  out  1  registered PWM output.
- `period_end`  out  1  one-cycle pulse at each period wrap.
- `duty`  out  8  currently active duty value.

## Operation
- **Prescaler:** `pcnt` counts 0..PRESC-1 and wraps. `tick` is asserted when `pcnt == PRESC-1`.
- **Step counter:** 8-bit `cnt` increments on `tick` and wraps 255→0.
  - Period = 256·PRESC clocks.
  - A commit event occurs on the edge where `tick` is high and `cnt == 255`.
- **Compare:** `pwm_out <= (cnt < duty_active)`.
  - duty 0 gives a constant low output.
  - duty 255 gives high for 255 of 256 steps; a fully-on output is not supported.
- **Shadow register:** `load` captures the filtered `num` into `duty_pending`.
- **FSM:**
  - IDLE: nothing pending.
    - `load` → PENDING.
  - PENDING: `duty_pending` is valid.
    - `load` → PENDING, overwriting `duty_pending` (last write wins).
    - Commit event → IDLE, `duty_active <= duty_pending`.
    - Commit event together with `load` in the same cycle → PENDING: the old `duty_pending` commits, and the new value becomes pending for the next period.
- **Commit in IDLE:** no change; `duty_active` is held.
- **`load_ack`:** high for exactly one cycle after every accepted `load`. Every `load` is accepted; there is no backpressure.
- **`duty` output:** mirrors `duty_active`.
- **Reset (asynchronous, at any time including mid-period) clears:**
  - `pcnt`, `cnt`, `duty_active`, `duty_pending` → 0;
  - state → IDLE;
  - `pwm_out`, `load_ack`, `period_end` → 0.

## Timing
- `load` sampled at edge N → `load_ack` high during cycle N+1.
- The commit edge updates `duty` and moves `cnt` from 255 to 0. `period_end` is registered high for the single cycle following that edge.
- `pwm_out` lags `cnt` by one clock; the first step of a new period uses the new duty.
- Load-to-effect latency is between 1 and 256·PRESC clocks, depending on the period phase.
- Back-to-back `load` strobes on consecutive cycles are legal. Each one gets its own `load_ack`.

## Configuration
- Macro: `ALU_PWM_FLAG_GUARD_EN`.
- **Defined:** the filter applied on capture is
  - `neg = 1` → duty_pending 0;
  - else `des = 1` → duty_pending 255;
  - else `num`.

  `neg` has priority over `des`.
- **Undefined:** `num` is captured unmodified and all flag inputs are ignored.

## Structure
- Package `alu_pwm_pkg` holds:
  - `DUTY_W = 8`;
  - `CNT_MAX = 8'hFF`;
  - `typedef enum logic {IDLE, PENDING} pwm_state_t`.
- Sub-module `pwm_prescaler` (parameter `PRESC`; ports `clk`, `rst`, `tick`) contains the prescaler counter. Everything else is in the top level.

## Test plan
1. **Idle after reset:** with PRESC=1, reset and issue no `load`.
   - `pwm_out` stays 0 for 600 cycles.
   - `period_end` pulses every 256 cycles.
   - `duty` stays 0.
2. **Single load:** with PRESC=1, apply `load` with num=128 at cycle 10.
   - `load_ack` pulses at cycle 11.
   - `duty` stays 0 until the first commit.
   - In the following period, `pwm_out` is high for 128 cycles and low for 128.
3. **Last write wins:** issue `load` 64, then `load` 200, within one period.
   - Only 200 commits; 64 never appears on `duty`.
4. **Flag guard:**
   - With the macro defined: neg=1, num=0xF7 → duty 0; des=1, num=30 → duty 255.
   - With the macro undefined, the same stimulus → duty 247 and duty 30.
5. **Reset mid-period:** with duty=100, assert `rst` at cnt=40.
   - `pwm_out`, `duty` and `cnt` go to 0 immediately.
   - After release, output stays low until a new load commits.
6. **Load on the commit edge:** with 50 pending, apply `load` 90 on the commit edge.
   - `duty` becomes 50 now and 90 at the next commit.
   - `load_ack` still pulses for the 90 load.
